// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS execute-stage Hi/Lo unit: op encoding, FSM states, iteration count.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } hilo_state_t;

  localparam int HILO_ITERS = 32;

endpackage

// File: rtl/mips_cpu_hilo_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and the final sign fix.
module mips_cpu_hilo_negate #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mips_cpu_hilo_unit.sv
// Hi/Lo special-register unit: iterative MULT/MULTU/DIV/DIVU, MTHI/MTLO writes, MFHI/MFLO reads.
module mips_cpu_hilo_unit
  import mips_cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = HILO_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  hilo_op_t        op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            rd_hi,
  input  logic            rd_lo,
  output logic [XLEN-1:0] rd_data,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  hilo_state_t       state;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvsr;
  logic              neg_q;
  logic              neg_r;
  logic              op_mul;

  logic              is_signed;
  logic [XLEN-1:0]   rs_mag;
  logic [XLEN-1:0]   rt_mag;
  logic [2*XLEN-1:0] fix_acc;
  logic [XLEN-1:0]   fix_rem;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     part;
  logic [XLEN-1:0]   diff;
  logic              ge;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  mips_cpu_hilo_negate #(.W(XLEN)) u_rs_mag (
    .neg (is_signed & rs_val[XLEN-1]),
    .a   (rs_val),
    .y   (rs_mag)
  );

  mips_cpu_hilo_negate #(.W(XLEN)) u_rt_mag (
    .neg (is_signed & rt_val[XLEN-1]),
    .a   (rt_val),
    .y   (rt_mag)
  );

  // Product for MUL; for DIV only the low half (quotient) is consumed.
  mips_cpu_hilo_negate #(.W(2*XLEN)) u_fix_acc (
    .neg (neg_q),
    .a   (acc),
    .y   (fix_acc)
  );

  mips_cpu_hilo_negate #(.W(XLEN)) u_fix_rem (
    .neg (neg_r),
    .a   (rem),
    .y   (fix_rem)
  );

  // Multiplier sits in acc low half and shifts out LSB-first; divisor trial uses a 33-bit window.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvsr} : '0);
  assign part    = {rem, acc[XLEN-1]};
  assign ge      = part >= {1'b0, dvsr};
  assign diff    = part[XLEN-1:0] - dvsr;

  assign busy    = (state != IDLE);
  assign stall   = busy & (op_valid | rd_hi | rd_lo);
  assign rd_data = rd_hi ? hi : (rd_lo ? lo : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (op_valid) begin
            case (op)
              OP_MULT, OP_MULTU: state <= MUL;
              OP_DIV,  OP_DIVU:  state <= DIV;
              OP_MTHI:           hi    <= rs_val;
              OP_MTLO:           lo    <= rs_val;
              default:           ;
            endcase
          end
        end
        MUL, DIV: begin
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITERS - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (op_mul) begin
            {hi, lo} <= fix_acc;
          end else begin
            lo <= fix_acc[XLEN-1:0];
            hi <= fix_rem;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: no reset; contents are only consumed after a fresh accept.
  // A zero divisor yields all-ones quotient and rem=|rs|; clearing neg_q keeps lo
  // at 0xFFFFFFFF and the neg_r fix restores hi to the original rs.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc    <= {{XLEN{1'b0}}, rt_mag};
              dvsr   <= rs_mag;
              neg_q  <= is_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
              neg_r  <= 1'b0;
              op_mul <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              acc    <= {{XLEN{1'b0}}, rs_mag};
              rem    <= '0;
              dvsr   <= rt_mag;
              neg_q  <= is_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]) & (rt_val != '0);
              neg_r  <= is_signed & rs_val[XLEN-1];
              op_mul <= 1'b0;
            end
            default: ;
          endcase
        end
      end
      MUL: acc <= {mul_sum, acc[XLEN-1:1]};
      DIV: begin
        acc[XLEN-1:0] <= {acc[XLEN-2:0], ge};
        rem           <= ge ? diff : part[XLEN-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Bench for mips_cpu_hilo_unit: arithmetic reference model, per-cycle compare, directed vectors.
module tb_mips_cpu_hilo_unit;
  import mips_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  hilo_op_t    op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  mips_cpu_hilo_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .rd_hi    (rd_hi),
    .rd_lo    (rd_lo),
    .rd_data  (rd_data),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi,lo} of a mult/div op, from plain integer arithmetic.
  function automatic logic [63:0] model_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (op_valid) begin
      case (3'(op))
        3'd0, 3'd1, 3'd2, 3'd3: begin
          m_pend <= model_op(3'(op), rs_val, rt_val);
          m_left <= 33;
        end
        3'd4: m_hi <= rs_val;
        3'd5: m_lo <= rs_val;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("stall", 32'(stall), 32'((m_left > 0) && (op_valid || rd_hi || rd_lo)));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (!stall) chk("rd_data", rd_data, rd_hi ? m_hi : (rd_lo ? m_lo : 32'h0));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    tick();
    op_valid = 1'b1;
    op       = hilo_op_t'(o);
    rs_val   = a;
    rt_val   = b;
    tick();
    op_valid = 1'b0;
    rs_val   = $urandom;
    rt_val   = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL %s busy did not drop within 60 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(o, a, b);
    wait_idle(name);
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    op_valid = 1'b0;
    op       = OP_MULT;
    rs_val   = '0;
    rt_val   = '0;
    rd_hi    = 1'b0;
    rd_lo    = 1'b0;
    tick();
    run_chk = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    n = 0;
    while (busy && n < 60) begin
      n++;
      tick();
    end
    chk("mult_busy_cycles", 32'(n), 32'd33);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFFA);

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m1sq", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF);

    // MFHI held from E5 of a MULT 6x7.
    issue(3'd0, 32'd6, 32'd7);
    repeat (4) tick();
    rd_hi = 1'b1;
    #1;
    chk("mfhi_stall", 32'(stall), 32'h1);
    n = 0;
    while (stall && n < 60) begin
      tick();
      n++;
    end
    chk("mfhi_released", 32'(stall), 32'h0);
    chk("mfhi_data", rd_data, 32'h0);
    rd_hi = 1'b0;
    rd_lo = 1'b1;
    #1;
    chk("mflo_data", rd_data, 32'd42);
    tick();
    rd_lo = 1'b0;

    issue(3'd4, 32'h0000_1234, 32'h0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo_kept", lo, 32'd42);
    chk("mthi_busy", 32'(busy), 32'h0);

    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    chk("op6_hi", hi, 32'h0000_1234);
    chk("op6_busy", 32'(busy), 32'h0);

    // MTLO held while a MULT 2x3 runs.
    issue(3'd0, 32'd2, 32'd3);
    op_valid = 1'b1;
    op       = OP_MTLO;
    rs_val   = 32'h0000_ABCD;
    #1;
    chk("mtlo_stall", 32'(stall), 32'h1);
    n = 0;
    while (stall && n < 60) begin
      tick();
      n++;
    end
    chk("mtlo_released", 32'(stall), 32'h0);
    chk("mtlo_lo_before", lo, 32'd6);
    tick();
    op_valid = 1'b0;
    chk("mtlo_lo_after", lo, 32'h0000_ABCD);
    chk("mtlo_hi_kept", hi, 32'h0);

    // Reset at E10 of a DIVU.
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    run_op("multu_3x5", 3'd1, 32'd3, 32'd5, 32'h0, 32'd15);

    tick();
    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
